muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 148 ++++++++++++++
 tb/tb_muldiv_unit.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative 32-bit multiply/divide unit with HI/LO registers
//
// Purpose: sequential MULT/MULTU/DIV/DIVU engine. One operation takes 34 edges
// from acceptance to return to IDLE: 32 iteration edges, a sign-fix edge that
// writes HI/LO, and one DONE edge. HI/LO can also be loaded directly (MTHI/MTLO)
// while idle, and read back through Rdata (MFHI/MFLO).
//
// Ports:
//   CLK    in   clock, rising edge
//   RST    in   synchronous active-high reset
//   Start  in   request operation (sampled in IDLE only)
//   Op     in   2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   Rs     in   32 operand A (multiplicand / dividend), MTHI/MTLO data
//   Rt     in   32 operand B (multiplier / divisor)
//   WrHi   in   load Rs into HI (IDLE only)
//   WrLo   in   load Rs into LO (IDLE only)
//   RdHi   in   Rdata select: 1 = HI, 0 = LO
//   Busy   out  state != IDLE
//   Done   out  one-cycle pulse after HI/LO are written
//   Hi     out  32 HI register
//   Lo     out  32 LO register
//   Rdata  out  32 RdHi ? Hi : Lo
module muldiv_unit (
   input  logic        CLK,
   input  logic        RST,
   input  logic        Start,
   input  logic [1:0]  Op,
   input  logic [31:0] Rs,
   input  logic [31:0] Rt,
   input  logic        WrHi,
   input  logic        WrLo,
   input  logic        RdHi,
   output logic        Busy,
   output logic        Done,
   output logic [31:0] Hi,
   output logic [31:0] Lo,
   output logic [31:0] Rdata
);

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t      state;
   logic        op_div;     // Op[1]: divide when set
   logic [4:0]  cnt;
   logic [31:0] m;          // multiplicand magnitude or divisor magnitude
   logic [63:0] p;          // mult: {partial sum, multiplier}; div: {remainder, dividend/quotient}
   logic        neg_res;    // operand signs differ (signed ops only)
   logic        neg_rem;    // dividend negative (signed ops only)
   logic        div_zero;

   // Operand magnitudes; Op[0]=0 selects the signed variants.
   logic        a_neg, b_neg;
   logic [31:0] a_mag, b_mag;

   assign a_neg = ~Op[0] & Rs[31];
   assign b_neg = ~Op[0] & Rt[31];
   assign a_mag = a_neg ? -Rs : Rs;
   assign b_mag = b_neg ? -Rt : Rt;

   // One shift-add step: add multiplicand to the upper half when the current
   // multiplier bit is set, then shift the whole 65-bit quantity right.
   logic [32:0] mul_sum;
   logic [63:0] mul_next;

   assign mul_sum  = {1'b0, p[63:32]} + (p[0] ? {1'b0, m} : 33'd0);
   assign mul_next = {mul_sum, p[31:1]};

   // One restoring-division step: the trial remainder is the current
   // remainder shifted left with the next dividend bit brought in. A borrow
   // in bit 33 means the divisor does not fit, so the remainder is kept.
   logic [33:0] div_diff;
   logic [63:0] div_next;

   assign div_diff = {1'b0, p[63:32], p[31]} - {2'b0, m};
   assign div_next = div_diff[33] ? {p[62:0], 1'b0}
                                  : {div_diff[31:0], p[30:0], 1'b1};

   // Final sign correction applied in FIX.
   logic [63:0] prod_fix;
   logic [31:0] quo_fix, rem_fix;

   assign prod_fix = neg_res ? -p : p;
   // A zero divisor leaves an all-ones quotient and the dividend magnitude as
   // remainder; the quotient is forced so that signed ops also read all-ones.
   assign quo_fix  = div_zero ? 32'hFFFF_FFFF : (neg_res ? -p[31:0] : p[31:0]);
   assign rem_fix  = neg_rem ? -p[63:32] : p[63:32];

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= IDLE;
         op_div   <= 1'b0;
         cnt      <= 5'd0;
         m        <= 32'd0;
         p        <= 64'd0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         div_zero <= 1'b0;
         Hi       <= 32'd0;
         Lo       <= 32'd0;
         Done     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               Done <= 1'b0;
               if (Start) begin
                  // Start takes priority; any simultaneous MTHI/MTLO is dropped.
                  state    <= RUN;
                  op_div   <= Op[1];
                  cnt      <= 5'd0;
                  m        <= Op[1] ? b_mag : a_mag;
                  p        <= Op[1] ? {32'd0, a_mag} : {32'd0, b_mag};
                  neg_res  <= a_neg ^ b_neg;
                  neg_rem  <= a_neg;
                  div_zero <= (Rt == 32'd0);
               end else begin
                  if (WrHi) Hi <= Rs;
                  if (WrLo) Lo <= Rs;
               end
            end
            RUN: begin
               p   <= op_div ? div_next : mul_next;
               cnt <= cnt + 5'd1;
               if (cnt == 5'd31) state <= FIX;
            end
            FIX: begin
               if (op_div) begin
                  Hi <= rem_fix;
                  Lo <= quo_fix;
               end else begin
                  Hi <= prod_fix[63:32];
                  Lo <= prod_fix[31:0];
               end
               Done  <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               Done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign Busy  = (state != IDLE);
   assign Rdata = RdHi ? Hi : Lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        Start = 1'b0;
   logic [1:0]  Op = 2'd0;
   logic [31:0] Rs = 32'd0;
   logic [31:0] Rt = 32'd0;
   logic        WrHi = 1'b0;
   logic        WrLo = 1'b0;
   logic        RdHi = 1'b0;
   logic        Busy, Done;
   logic [31:0] Hi, Lo, Rdata;

   int tests_run = 0;
   int tests_failed = 0;

   localparam int LATENCY = 33;

   muldiv_unit dut (
      .CLK   (CLK),
      .RST   (RST),
      .Start (Start),
      .Op    (Op),
      .Rs    (Rs),
      .Rt    (Rt),
      .WrHi  (WrHi),
      .WrLo  (WrLo),
      .RdHi  (RdHi),
      .Busy  (Busy),
      .Done  (Done),
      .Hi    (Hi),
      .Lo    (Lo),
      .Rdata (Rdata)
   );

   always #5 CLK = ~CLK;

   // Reference model: plain 64-bit arithmetic.
   function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo);
      longint      sa, sb, q, r;
      logic [63:0] t;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         2'd0: begin t = sa * sb; hi = t[63:32]; lo = t[31:0]; end
         2'd1: begin t = {32'd0, a} * {32'd0, b}; hi = t[63:32]; lo = t[31:0]; end
         default: begin
            if (b == 32'd0) begin
               hi = a; lo = 32'hFFFF_FFFF;
            end else if (op == 2'd2) begin
               q = sa / sb; r = sa % sb;
               t = q; lo = t[31:0];
               t = r; hi = t[31:0];
            end else begin
               lo = a / b; hi = a % b;
            end
         end
      endcase
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Issue an operation from IDLE (caller sits #1 after an edge) and wait for
   // Done. lat = edges from acceptance to Done (0 on timeout); early = HI/LO
   // moved before Done.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output bit early);
      logic [31:0] h0, l0;
      h0 = Hi; l0 = Lo;
      lat = 0; early = 1'b0;
      Start = 1'b1; Op = op; Rs = a; Rt = b;
      tick();
      Start = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (Done) begin
            lat = k;
            break;
         end
         if (Hi !== h0 || Lo !== l0) early = 1'b1;
      end
   endtask

   task automatic test_reset();
      RST = 1'b1; Start = 1'b1; WrHi = 1'b1; WrLo = 1'b1; Rs = 32'hDEAD_BEEF;
      tick();
      tick();
      RST = 1'b0; Start = 1'b0; WrHi = 1'b0; WrLo = 1'b0;
      tests_run++;
      if (Busy !== 1'b0 || Done !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_ctrl: got Busy=%b Done=%b exp 0 0", Busy, Done);
      end
      tests_run++;
      if (Hi !== 32'd0 || Lo !== 32'd0 || Rdata !== 32'd0) begin
         tests_failed++;
         $display("FAIL reset_hilo: got Hi=%h Lo=%h Rdata=%h exp 0", Hi, Lo, Rdata);
      end
   endtask

   task automatic test_multu_latency();
      int lat; bit early;
      Start = 1'b1; Op = 2'd1; Rs = 32'hFFFF_FFFF; Rt = 32'hFFFF_FFFF;
      tick();
      Start = 1'b0;
      tests_run++;
      if (Busy !== 1'b1 || Done !== 1'b0) begin
         tests_failed++;
         $display("FAIL multu_after_e0: got Busy=%b Done=%b exp 1 0", Busy, Done);
      end
      lat = 0; early = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (Done) begin lat = k; break; end
      end
      tests_run++;
      if (lat != LATENCY) begin
         tests_failed++;
         $display("FAIL multu_latency: got %0d exp %0d", lat, LATENCY);
      end
      tests_run++;
      if (Hi !== 32'hFFFF_FFFE || Lo !== 32'h0000_0001) begin
         tests_failed++;
         $display("FAIL multu_result: got %h_%h exp fffffffe_00000001", Hi, Lo);
      end
      tick();
      tests_run++;
      if (Busy !== 1'b0 || Done !== 1'b0) begin
         tests_failed++;
         $display("FAIL multu_after_e34: got Busy=%b Done=%b exp 0 0", Busy, Done);
      end
   endtask

   task automatic test_directed();
      logic [1:0]  ops [5]   = '{2'd0, 2'd2, 2'd2, 2'd3, 2'd2};
      logic [31:0] as  [5]   = '{32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h8000_0000, 32'd7, 32'hFFFF_FFF9};
      logic [31:0] bs  [5]   = '{32'd5, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'd0};
      logic [31:0] ehi [5]   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd7, 32'hFFFF_FFF9};
      logic [31:0] elo [5]   = '{32'hFFFF_FFF1, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      int lat; bit early;
      for (int i = 0; i < 5; i++) begin
         run_op(ops[i], as[i], bs[i], lat, early);
         tests_run++;
         if (lat != LATENCY) begin
            tests_failed++;
            $display("FAIL directed%0d_latency: got %0d exp %0d", i, lat, LATENCY);
         end
         tests_run++;
         if (Hi !== ehi[i] || Lo !== elo[i]) begin
            tests_failed++;
            $display("FAIL directed%0d_result: got %h_%h exp %h_%h", i, Hi, Lo, ehi[i], elo[i]);
         end
         RdHi = 1'b0;
         #1;
         tests_run++;
         if (Rdata !== elo[i]) begin
            tests_failed++;
            $display("FAIL directed%0d_rdata_lo: got %h exp %h", i, Rdata, elo[i]);
         end
         tick();
      end
   endtask

   task automatic test_mthi_mtlo();
      int lat; bit early;
      WrHi = 1'b1; Rs = 32'hA5A5_0001;
      tick();
      WrHi = 1'b0; WrLo = 1'b1; Rs = 32'h5A5A_0002;
      tick();
      WrLo = 1'b0;
      RdHi = 1'b1;
      #1;
      tests_run++;
      if (Hi !== 32'hA5A5_0001 || Rdata !== 32'hA5A5_0001) begin
         tests_failed++;
         $display("FAIL mthi: got Hi=%h Rdata=%h exp a5a50001", Hi, Rdata);
      end
      RdHi = 1'b0;
      #1;
      tests_run++;
      if (Lo !== 32'h5A5A_0002 || Rdata !== 32'h5A5A_0002) begin
         tests_failed++;
         $display("FAIL mtlo: got Lo=%h Rdata=%h exp 5a5a0002", Lo, Rdata);
      end
      WrHi = 1'b1; WrLo = 1'b1; Rs = 32'h0BAD_CAFE;
      tick();
      WrHi = 1'b0; WrLo = 1'b0;
      tests_run++;
      if (Hi !== 32'h0BAD_CAFE || Lo !== 32'h0BAD_CAFE) begin
         tests_failed++;
         $display("FAIL mthi_mtlo_both: got %h_%h exp 0badcafe_0badcafe", Hi, Lo);
      end
      // Start with WrHi/WrLo held high throughout: the writes must never land.
      WrHi = 1'b1; WrLo = 1'b1;
      run_op(2'd1, 32'h0000_1234, 32'd3, lat, early);
      WrHi = 1'b0; WrLo = 1'b0;
      tests_run++;
      if (early !== 1'b0 || lat != LATENCY) begin
         tests_failed++;
         $display("FAIL start_beats_write: got early=%b lat=%0d exp 0 %0d", early, lat, LATENCY);
      end
      tests_run++;
      if (Hi !== 32'd0 || Lo !== 32'h0000_369C) begin
         tests_failed++;
         $display("FAIL start_beats_write_result: got %h_%h exp 00000000_0000369c", Hi, Lo);
      end
      tick();
   endtask

   task automatic test_busy_ignore();
      int lat;
      Start = 1'b1; Op = 2'd3; Rs = 32'd100; Rt = 32'd7;
      tick();
      Start = 1'b0;
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         if (k == 5) begin
            Start = 1'b1; Op = 2'd1; WrLo = 1'b1; Rs = 32'h1234; Rt = 32'd9;
         end else begin
            Start = 1'b0; WrLo = 1'b0;
         end
         tick();
         if (Done) begin lat = k; break; end
      end
      Start = 1'b0; WrLo = 1'b0;
      tests_run++;
      if (lat != LATENCY) begin
         tests_failed++;
         $display("FAIL busy_ignore_latency: got %0d exp %0d", lat, LATENCY);
      end
      tests_run++;
      if (Lo !== 32'd14 || Hi !== 32'd2) begin
         tests_failed++;
         $display("FAIL busy_ignore_result: got %h_%h exp 00000002_0000000e", Hi, Lo);
      end
      tick();
      tests_run++;
      if (Busy !== 1'b0 || Done !== 1'b0) begin
         tests_failed++;
         $display("FAIL busy_ignore_idle: got Busy=%b Done=%b exp 0 0", Busy, Done);
      end
   endtask

   task automatic test_reset_mid();
      int lat; bit early;
      WrHi = 1'b1; WrLo = 1'b1; Rs = 32'h1111_2222;
      tick();
      WrHi = 1'b0; WrLo = 1'b0;
      Start = 1'b1; Op = 2'd1; Rs = 32'hFFFF_0000; Rt = 32'h0001_0003;
      tick();                       // E0
      Start = 1'b0;
      for (int k = 1; k <= 9; k++) tick();
      RST = 1'b1; Start = 1'b1; WrHi = 1'b1;
      tick();                       // E10
      RST = 1'b0; Start = 1'b0; WrHi = 1'b0;
      tests_run++;
      if (Busy !== 1'b0 || Done !== 1'b0 || Hi !== 32'd0 || Lo !== 32'd0) begin
         tests_failed++;
         $display("FAIL reset_mid: got Busy=%b Done=%b Hi=%h Lo=%h exp 0 0 0 0", Busy, Done, Hi, Lo);
      end
      run_op(2'd1, 32'h0001_0001, 32'h0001_0001, lat, early);   // accepted at E11
      tests_run++;
      if (lat != LATENCY || Hi !== 32'd1 || Lo !== 32'h0002_0001) begin
         tests_failed++;
         $display("FAIL reset_mid_restart: got lat=%0d %h_%h exp %0d 00000001_00020001", lat, Hi, Lo, LATENCY);
      end
      tick();
   endtask

   task automatic test_random();
      logic [31:0] a, b, ehi, elo;
      logic [1:0]  op;
      logic [31:0] corner [6] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd2};
      int lat; bit early;
      for (int i = 0; i < 30; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
         case ($urandom_range(0, 3))
            0: b = corner[$urandom_range(0, 5)];
            1: b = $urandom_range(1, 300);
            default: b = $urandom;
         endcase
         model(op, a, b, ehi, elo);
         run_op(op, a, b, lat, early);
         tests_run++;
         if (lat != LATENCY || early !== 1'b0) begin
            tests_failed++;
            $display("FAIL random%0d_timing: got lat=%0d early=%b exp %0d 0", i, lat, early, LATENCY);
         end
         tests_run++;
         if (Hi !== ehi || Lo !== elo) begin
            tests_failed++;
            $display("FAIL random%0d_result op=%0d a=%h b=%h: got %h_%h exp %h_%h", i, op, a, b, Hi, Lo, ehi, elo);
         end
         RdHi = 1'b1;
         #1;
         tests_run++;
         if (Rdata !== ehi) begin
            tests_failed++;
            $display("FAIL random%0d_rdata_hi: got %h exp %h", i, Rdata, ehi);
         end
         RdHi = 1'b0;
         tick();
         tests_run++;
         if (Done !== 1'b0 || Busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL random%0d_done_pulse: got Busy=%b Done=%b exp 0 0", i, Busy, Done);
         end
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_multu_latency();
      test_directed();
      test_mthi_mtlo();
      test_busy_ignore();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
